// File: rtl/sram_1rw1r_init_bypass.sv
// 1RW1R single-clock SRAM model: hardware init clear, registered reads with valid strobes,
// write-first forwarding on same-address collisions. Optional macro SRAM_OUT_REG_EN adds an output stage.
module sram_1rw1r_init_bypass #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
   parameter int NUM_WMASKS = DATA_WIDTH / 8,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk0,
   input  logic                  rstb,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic                  dvalid0,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  dvalid1,
   output logic                  init_busy,
   output logic                  collision
);

   // state   | meaning
   // ST_INIT | sequencer clears one word per cycle, ports ignored
   // ST_RUN  | normal port operation

   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("DATA_WIDTH must be a multiple of 8");
   end

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic                  run;
   logic                  wr0;
   logic                  rd0;
   logic                  rd1;
   logic                  hit;
   logic [DATA_WIDTH-1:0] wr_word;

   logic [DATA_WIDTH-1:0] dout0_s;
   logic [DATA_WIDTH-1:0] dout1_s;
   logic                  dvalid0_s;
   logic                  dvalid1_s;
   logic                  collision_s;

   assign run = (state == ST_RUN);
   assign wr0 = run & ~csb0 & ~web0;
   assign rd0 = run & ~csb0 & web0;
   assign rd1 = run & ~csb1;
   assign hit = wr0 & (|wmask0) & rd1 & (addr0 == addr1);

   // Merged word is both what gets stored and what port 1 sees on a collision.
   always_comb begin
      wr_word = mem[addr0];
      for (int i = 0; i < NUM_WMASKS; i++) begin
         if (wmask0[i]) wr_word[8*i +: 8] = din0[8*i +: 8];
      end
   end

   always_ff @(posedge clk0) begin
      if (state == ST_INIT) mem[init_cnt] <= INIT_VALUE;
      else if (wr0)         mem[addr0]    <= wr_word;
   end

   always_ff @(posedge clk0 or negedge rstb) begin
      if (!rstb) begin
         state       <= ST_INIT;
         init_cnt    <= '0;
         init_busy   <= 1'b1;
         dout0_s     <= '0;
         dout1_s     <= '0;
         dvalid0_s   <= 1'b0;
         dvalid1_s   <= 1'b0;
         collision_s <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               if (init_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                  state     <= ST_RUN;
                  init_busy <= 1'b0;
               end else begin
                  init_cnt  <= init_cnt + 1'b1;
               end
            end
            default: state <= ST_RUN;
         endcase
         dvalid0_s   <= rd0;
         dvalid1_s   <= rd1;
         collision_s <= hit;
         if (rd0) dout0_s <= mem[addr0];
         if (hit)      dout1_s <= wr_word;
         else if (rd1) dout1_s <= mem[addr1];
      end
   end

`ifdef SRAM_OUT_REG_EN
   always_ff @(posedge clk0 or negedge rstb) begin
      if (!rstb) begin
         dout0     <= '0;
         dout1     <= '0;
         dvalid0   <= 1'b0;
         dvalid1   <= 1'b0;
         collision <= 1'b0;
      end else begin
         dout0     <= dout0_s;
         dout1     <= dout1_s;
         dvalid0   <= dvalid0_s;
         dvalid1   <= dvalid1_s;
         collision <= collision_s;
      end
   end
`else
   assign dout0     = dout0_s;
   assign dout1     = dout1_s;
   assign dvalid0   = dvalid0_s;
   assign dvalid1   = dvalid1_s;
   assign collision = collision_s;
`endif

endmodule

// File: doc/sram_1rw1r_init_bypass.md
Name: sram_1rw1r_init_bypass

Overview:
- Parametrised successor to the team's 32x32 1RW1R behavioural SRAM model. Generic width and depth, with byte-granular write masks.
- Both ports run on a single clock. Changes from the previous model:
  - after reset, a hardware init sequencer clears every word;
  - read data is registered and qualified by a valid strobe;
  - a same-address write/read collision is forwarded write-first and flagged.
- Sits between core-side load/store logic and the physical macro wrapper. Used for simulation and as the golden model in macro-equivalence benches.

Parameters:
- DATA_WIDTH, 32, word width in bits. Must be a multiple of 8; elaboration fails otherwise.
- ADDR_WIDTH, 5, address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words. Derived; do not override.
- NUM_WMASKS, DATA_WIDTH/8, number of byte write-mask bits. Derived.
- INIT_VALUE, 0, value written to every word during init. DATA_WIDTH bits.

Ports:
- clk0  in  1  clock shared by both ports; all logic is posedge.
- rstb  in  1  reset, asynchronous, active-low.
- csb0  in  1  port 0 chip select, active-low.
- web0  in  1  port 0 write enable, active-low (0 = write, 1 = read).
- wmask0  in  NUM_WMASKS  port 0 byte write mask; bit i enables byte i.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dvalid0  out  1  dout0 valid strobe.
- csb1  in  1  port 1 (read-only) chip select, active-low.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.
- dvalid1  out  1  dout1 valid strobe.
- init_busy  out  1  high while the init sequencer runs.
- collision  out  1  one-cycle pulse on a same-address write/read.

Behaviour:
- Reset (rstb low, asynchronous, takes effect immediately):
  - dout0 = 0, dout1 = 0, dvalid0 = 0, dvalid1 = 0, collision = 0;
  - init_busy = 1, init counter = 0, FSM = INIT.
  - Memory contents are undefined until init completes.
- FSM states: INIT, RUN.
  - INIT: each posedge writes INIT_VALUE to mem[cnt], then cnt increments.
  - On the edge that writes word RAM_DEPTH-1: move to RUN, deassert init_busy at that edge, do not wrap cnt.
  - Init takes exactly RAM_DEPTH cycles after rstb deasserts.
- During INIT, all port requests are ignored: no write, dvalid stays 0, collision stays 0.
- RUN, port 0 write (csb0=0, web0=0):
  - at the posedge, each byte i with wmask0[i]=1 gets din0 byte i; other bytes are unchanged;
  - dvalid0 = 0;
  - wmask0 = 0 is a legal no-op.
- RUN, port 0 read (csb0=0, web0=1):
  - dout0 <= mem[addr0] at the posedge; one-cycle latency;
  - dvalid0 = 1 for exactly the following cycle.
- RUN, port 1 read (csb1=0): dout1 <= mem[addr1], dvalid1 = 1, same timing as port 0.
- Outputs when no read is issued: dout holds its last value (never X); dvalid = 0.
- Back-to-back reads every cycle are supported; dvalid stays high continuously.
- Collision: port 0 write with wmask0 != 0, csb1 = 0, and addr0 == addr1 in the same cycle.
  - dout1 = merged word: new bytes where the mask is set, old bytes elsewhere (write-first);
  - collision = 1 for the cycle dout1 is valid.
  - Port 0 write and port 1 read to different addresses proceed independently; collision = 0.
- Port 0 read of an address written in the previous cycle returns the new data, because the write is committed at the edge.
- Reset asserted mid-RUN: outputs clear immediately and init restarts; previously written data is not preserved.

Optional Feature:
- Macro SRAM_OUT_REG_EN.
- Defined: adds a second output register stage on both ports.
  - Read latency becomes 2 cycles.
  - dvalid0, dvalid1 and collision are delayed one stage so they stay aligned with the data.
  - The added stage resets to 0.
- Undefined: single-stage, 1-cycle latency as described in Behaviour.

Test Plan:
1. Release rstb at cycle 0 -> init_busy high for exactly 32 cycles, then low. Port 1 read of addr 5 -> dout1 = 0x00000000, with dvalid1 high one cycle later.
2. Write 0xDEADBEEF to addr 3 with wmask0 = 4'b1111, then port 0 read of addr 3 next cycle -> dout0 = 0xDEADBEEF, dvalid0 pulses for 1 cycle.
3. Write 0x11223344 to addr 3 with wmask0 = 4'b0101, then read addr 3 -> 0xDE22BE44.
4. Same cycle: port 0 writes 0xCAFEF00D to addr 7 (mask 1111, old value 0) and port 1 reads addr 7 -> dout1 = 0xCAFEF00D, collision = 1 for one cycle. Repeat with mask 0011 -> dout1 = 0x0000F00D.
5. Write 0xFFFFFFFF to addr 2 while init_busy = 1, then read addr 2 after init -> 0x00000000.
6. Pull rstb low between edges mid-run -> dout0/dout1 = 0, dvalid = 0, init_busy = 1 immediately. After re-init, addr 3 reads 0. With SRAM_OUT_REG_EN defined, scenario 2 shows dvalid0 two cycles after the request.
